fpu_apu_initiator: RTL and testbench

- Core-side master for the shared-FPU APU protocol (req/gnt request channel, rvalid/rID response channel). It is the requesting end of the FPU wrapper's slave port.
- Registers core requests, allocates a transaction slot and sends ID = {SRC_ID, slot}. It accepts out-of-order responses by ID, restores the core tag and buffers results in a response FIFO.
- The responder ignores apu_rready, so the block enforces credit-based flow control: every response always has a FIFO entry reserved for it.

---
 rtl/fpu_apu_initiator.sv | 212 +++++++++++++++++++++
 tb/tb_fpu_apu_initiator.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_apu_initiator.sv
`default_nettype none
// ============================================================================
// Module  : fpu_apu_initiator
// Purpose : Core-side master for the shared-FPU APU protocol. It registers
//           core requests, tags each one with ID = {SRC_ID, slot}, accepts
//           out-of-order responses by ID, restores the core tag and buffers
//           results in a response FIFO. The responder never honours
//           apu_rready, so a request is only accepted while a FIFO entry can
//           be reserved for its response (credit flow control).
// Ports   : clk, rst_n                 clock, async active-low reset
//           core_req/gnt/operands/op/flags/tag      core request channel
//           core_rvalid/rready/rdata/rflags/rtag    core response channel
//           apu_req/gnt/ID/operands/op/flags        APU request channel
//           apu_rready/rvalid/rdata/rflags/rID      APU response channel
//           resp_err_o  one-cycle pulse when a response is dropped
//           busy_o      transactions in flight or buffered
// Revision: 1.0 - initial release
// ============================================================================
module fpu_apu_initiator #(
  parameter int ID_WIDTH        = 9,
  parameter int NB_SLOTS        = 4,
  parameter int SRC_ID          = 0,
  parameter int NB_ARGS         = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_WIDTH    = 6,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int CORE_TAG_WIDTH  = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          core_req_i,
  output logic                          core_gnt_o,
  input  logic [NB_ARGS*DATA_WIDTH-1:0] core_operands_i,
  input  logic [OPCODE_WIDTH-1:0]       core_op_i,
  input  logic [FLAGS_IN_WIDTH-1:0]     core_flags_i,
  input  logic [CORE_TAG_WIDTH-1:0]     core_tag_i,
  output logic                          core_rvalid_o,
  input  logic                          core_rready_i,
  output logic [DATA_WIDTH-1:0]         core_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]    core_rflags_o,
  output logic [CORE_TAG_WIDTH-1:0]     core_rtag_o,
  output logic                          apu_req_o,
  input  logic                          apu_gnt_i,
  output logic [ID_WIDTH-1:0]           apu_ID_o,
  output logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_o,
  output logic [OPCODE_WIDTH-1:0]       apu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]     apu_flags_o,
  output logic                          apu_rready_o,
  input  logic                          apu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         apu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]    apu_rflags_i,
  input  logic [ID_WIDTH-1:0]           apu_rID_i,
  output logic                          resp_err_o,
  output logic                          busy_o
);

  localparam int                  SLOT_BITS = $clog2(NB_SLOTS);
  localparam int                  SRC_BITS  = ID_WIDTH - SLOT_BITS;
  localparam int                  ENTRY_W   = DATA_WIDTH + FLAGS_OUT_WIDTH + CORE_TAG_WIDTH;
  localparam logic [SRC_BITS-1:0] SRC_VAL   = SRC_BITS'(SRC_ID);
  localparam logic [SLOT_BITS:0]  CNT_MAX   = (SLOT_BITS + 1)'(NB_SLOTS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } req_state_t;

  req_state_t                state_q, state_d;
  logic                      pend;
  logic [NB_SLOTS-1:0]       busy_q, busy_d;
  logic [SLOT_BITS-1:0]      free_slot;
  logic                      free_any;
  logic                      accept;
  logic [SLOT_BITS:0]        credits_q;
  logic [CORE_TAG_WIDTH-1:0] tag_table [NB_SLOTS];
  logic                      resp_err_q;

  logic [SLOT_BITS-1:0]      rsp_slot;
  logic                      rsp_hit;

  logic [ENTRY_W-1:0]        fifo_mem [NB_SLOTS];
  logic [SLOT_BITS-1:0]      wr_ptr_q, rd_ptr_q;
  logic [SLOT_BITS:0]        fifo_cnt_q;
  logic                      push, pop;

  assign pend = (state_q == ST_PEND);

  // Lowest-index free slot, taken from the registered bitmap so a slot freed
  // by a response this cycle only becomes allocatable next cycle.
  always_comb begin
    free_slot = '0;
    free_any  = 1'b0;
    for (int i = NB_SLOTS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_slot = SLOT_BITS'(i);
        free_any  = 1'b1;
      end
    end
  end

  // Grant only while a response entry can be reserved; a pending request
  // may be replaced in the same cycle it is granted (back-to-back issue).
  assign core_gnt_o = (credits_q < CNT_MAX) && free_any && (!pend || apu_gnt_i);
  assign accept     = core_req_i && core_gnt_o;

  // Request FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PEND;
      ST_PEND: if (apu_gnt_i && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign apu_req_o    = pend;
  assign apu_rready_o = 1'b1;

  // Request register: loads only on accept, so it holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apu_ID_o       <= '0;
      apu_operands_o <= '0;
      apu_op_o       <= '0;
      apu_flags_o    <= '0;
    end else if (accept) begin
      apu_ID_o       <= {SRC_VAL, free_slot};
      apu_operands_o <= core_operands_i;
      apu_op_o       <= core_op_i;
      apu_flags_o    <= core_flags_i;
    end
  end

  // Response decode: only our own source ID hitting an occupied slot counts.
  assign rsp_slot = apu_rID_i[SLOT_BITS-1:0];
  assign rsp_hit  = apu_rvalid_i && (apu_rID_i[ID_WIDTH-1:SLOT_BITS] == SRC_VAL)
                    && busy_q[rsp_slot];

  // The accepted slot is free in busy_q and the hit slot is busy in busy_q,
  // so set and clear never target the same bit.
  always_comb begin
    busy_d = busy_q;
    if (rsp_hit) busy_d[rsp_slot]  = 1'b0;
    if (accept)  busy_d[free_slot] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < NB_SLOTS; i++) tag_table[i] <= '0;
    end else begin
      busy_q     <= busy_d;
      resp_err_q <= apu_rvalid_i && !rsp_hit;
      if (accept) tag_table[free_slot] <= core_tag_i;
    end
  end

  assign resp_err_o = resp_err_q;

  // Response FIFO (depth NB_SLOTS, power of two so pointers wrap naturally)
  assign push = rsp_hit;
  assign pop  = core_rready_i && (fifo_cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < NB_SLOTS; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= {apu_rdata_i, apu_rflags_i, tag_table[rsp_slot]};
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  assign core_rvalid_o = (fifo_cnt_q != '0);
  assign {core_rdata_o, core_rflags_o, core_rtag_o} = fifo_mem[rd_ptr_q];

  // Credits: slots in flight plus buffered responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= '0;
    end else if (accept && !pop) begin
      credits_q <= credits_q + 1'b1;
    end else if (pop && !accept) begin
      credits_q <= credits_q - 1'b1;
    end
  end

  assign busy_o = (credits_q != '0);

`ifndef SYNTHESIS
  // Every accepted request reserved an entry, so a push never meets a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                    !(push && !pop && (fifo_cnt_q == CNT_MAX)))
    else $error("response FIFO overflow");
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_apu_initiator.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_apu_initiator
// Purpose : Self-checking bench for fpu_apu_initiator. A transaction-level
//           model (slot occupancy, tag table, response queue, credit count)
//           predicts grants, the issued request and the core response stream.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_fpu_apu_initiator;

  localparam int NB  = 4;
  localparam int SRC = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req_i, core_gnt_o;
  logic [95:0] core_operands_i;
  logic [5:0]  core_op_i;
  logic [14:0] core_flags_i;
  logic [4:0]  core_tag_i;
  logic        core_rvalid_o, core_rready_i;
  logic [31:0] core_rdata_o;
  logic [4:0]  core_rflags_o, core_rtag_o;
  logic        apu_req_o, apu_gnt_i;
  logic [8:0]  apu_ID_o;
  logic [95:0] apu_operands_o;
  logic [5:0]  apu_op_o;
  logic [14:0] apu_flags_o;
  logic        apu_rready_o, apu_rvalid_i;
  logic [31:0] apu_rdata_i;
  logic [4:0]  apu_rflags_i;
  logic [8:0]  apu_rID_i;
  logic        resp_err_o, busy_o;

  fpu_apu_initiator #(.SRC_ID(SRC)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_operands_i(core_operands_i), .core_op_i(core_op_i),
    .core_flags_i(core_flags_i), .core_tag_i(core_tag_i),
    .core_rvalid_o(core_rvalid_o), .core_rready_i(core_rready_i),
    .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o), .core_rtag_o(core_rtag_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_ID_o(apu_ID_o),
    .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
    .apu_rready_o(apu_rready_o), .apu_rvalid_i(apu_rvalid_i),
    .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i), .apu_rID_i(apu_rID_i),
    .resp_err_o(resp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  f;
    logic [4:0]  t;
  } ent_t;

  // Reference model
  int          m_credits;
  bit [NB-1:0] m_busy;
  logic [4:0]  m_tag [NB];
  bit          m_pend;
  bit          m_err;
  logic [8:0]  m_id;
  logic [95:0] m_ops;
  logic [5:0]  m_op;
  logic [14:0] m_flags;
  ent_t        m_fifo [$];

  int n_chk = 0;
  int n_pass = 0;

  function automatic bit exp_gnt();
    return (m_credits < NB) && (m_busy != '1) && (!m_pend || apu_gnt_i);
  endfunction

  task automatic model_clear();
    m_credits = 0; m_busy = '0; m_pend = 0; m_err = 0;
    m_id = '0; m_ops = '0; m_op = '0; m_flags = '0;
    for (int i = 0; i < NB; i++) m_tag[i] = '0;
    m_fifo.delete();
  endtask

  task automatic idle_inputs();
    core_req_i = 0; core_operands_i = '0; core_op_i = '0; core_flags_i = '0;
    core_tag_i = '0; core_rready_i = 0; apu_gnt_i = 0; apu_rvalid_i = 0;
    apu_rdata_i = '0; apu_rflags_i = '0; apu_rID_i = '0;
  endtask

  task automatic rand_payload();
    core_operands_i = {$urandom, $urandom, $urandom};
    core_op_i       = 6'($urandom);
    core_flags_i    = 15'($urandom);
    core_tag_i      = 5'($urandom);
  endtask

  // Advance one clock: update the model from the inputs driven this cycle,
  // then step past the edge.
  task automatic tick();
    bit   acc;
    int   a;
    int   rs;
    ent_t e;
    acc = core_req_i && exp_gnt();
    a = 0;
    for (int i = NB - 1; i >= 0; i--) if (!m_busy[i]) a = i;
    if (core_rready_i && m_fifo.size() > 0) begin
      void'(m_fifo.pop_front());
      m_credits--;
    end
    m_err = 1'b0;
    if (apu_rvalid_i) begin
      rs = int'(apu_rID_i[1:0]);
      if (apu_rID_i[8:2] == 7'(SRC) && m_busy[rs]) begin
        e.d = apu_rdata_i; e.f = apu_rflags_i; e.t = m_tag[rs];
        m_fifo.push_back(e);
        m_busy[rs] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (acc) begin
      m_busy[a] = 1'b1; m_tag[a] = core_tag_i; m_id = {7'(SRC), 2'(a)};
      m_ops = core_operands_i; m_op = core_op_i; m_flags = core_flags_i;
      m_pend = 1'b1; m_credits++;
    end else if (m_pend && apu_gnt_i) begin
      m_pend = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Grant every pending request, answer every open slot, pop everything.
  task automatic flush();
    core_req_i = 0; apu_gnt_i = 1; core_rready_i = 0; apu_rvalid_i = 0;
    tick();
    apu_gnt_i = 0;
    for (int s = 0; s < NB; s++) begin
      if (m_busy[s]) begin
        apu_rvalid_i = 1; apu_rID_i = 9'(s); apu_rdata_i = $urandom; apu_rflags_i = 5'($urandom);
        tick();
      end
    end
    apu_rvalid_i = 0; core_rready_i = 1;
    while (m_fifo.size() > 0) tick();
    core_rready_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (apu_req_o !== 1'b0) $display("FAIL rst_req got=%b exp=0", apu_req_o); else n_pass++;
    n_chk++; if (apu_ID_o !== 9'd0) $display("FAIL rst_id got=%h exp=0", apu_ID_o); else n_pass++;
    n_chk++; if (apu_operands_o !== 96'd0) $display("FAIL rst_ops got=%h exp=0", apu_operands_o); else n_pass++;
    n_chk++; if (core_rvalid_o !== 1'b0) $display("FAIL rst_rvalid got=%b exp=0", core_rvalid_o); else n_pass++;
    n_chk++; if (resp_err_o !== 1'b0) $display("FAIL rst_err got=%b exp=0", resp_err_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy_o); else n_pass++;
    n_chk++; if (apu_rready_o !== 1'b1) $display("FAIL rst_rready got=%b exp=1", apu_rready_o); else n_pass++;
    n_chk++; if (core_gnt_o !== 1'b1) $display("FAIL rst_gnt got=%b exp=1", core_gnt_o); else n_pass++;
  endtask

  task automatic test_single_op();
    logic [95:0] ops;
    do_reset();
    rand_payload(); core_tag_i = 5'h07; ops = core_operands_i; core_req_i = 1;
    #1;
    n_chk++; if (core_gnt_o !== 1'b1) $display("FAIL single_gnt got=%b exp=1", core_gnt_o); else n_pass++;
    tick();
    core_req_i = 0; apu_gnt_i = 1;
    n_chk++; if (apu_req_o !== 1'b1) $display("FAIL single_req got=%b exp=1", apu_req_o); else n_pass++;
    n_chk++; if (apu_ID_o !== 9'd0) $display("FAIL single_id got=%h exp=0", apu_ID_o); else n_pass++;
    n_chk++; if (apu_operands_o !== ops) $display("FAIL single_ops got=%h exp=%h", apu_operands_o, ops); else n_pass++;
    tick();
    apu_gnt_i = 0;
    n_chk++; if (apu_req_o !== 1'b0) $display("FAIL single_req_drop got=%b exp=0", apu_req_o); else n_pass++;
    tick(); tick();
    apu_rvalid_i = 1; apu_rID_i = 9'd0; apu_rdata_i = 32'h3F800000; apu_rflags_i = 5'h01;
    tick();
    apu_rvalid_i = 0;
    n_chk++; if (core_rvalid_o !== 1'b1) $display("FAIL single_rvalid got=%b exp=1", core_rvalid_o); else n_pass++;
    n_chk++; if (core_rdata_o !== 32'h3F800000) $display("FAIL single_data got=%h exp=3f800000", core_rdata_o); else n_pass++;
    n_chk++; if (core_rtag_o !== 5'h07) $display("FAIL single_tag got=%h exp=07", core_rtag_o); else n_pass++;
    n_chk++; if (core_rflags_o !== 5'h01) $display("FAIL single_flags got=%h exp=01", core_rflags_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy_o); else n_pass++;
    core_rready_i = 1;
    tick();
    core_rready_i = 0;
    n_chk++; if (core_rvalid_o !== 1'b0) $display("FAIL single_rvalid_end got=%b exp=0", core_rvalid_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL single_busy_end got=%b exp=0", busy_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int order [4] = '{2, 0, 3, 1};
    do_reset();
    core_req_i = 1; apu_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      rand_payload(); core_tag_i = 5'(8 + i);
      #1;
      n_chk++; if (core_gnt_o !== 1'b1) $display("FAIL b2b_gnt%0d got=%b exp=1", i, core_gnt_o); else n_pass++;
      tick();
      n_chk++; if (apu_ID_o !== 9'(i)) $display("FAIL b2b_id%0d got=%h exp=%h", i, apu_ID_o, 9'(i)); else n_pass++;
      n_chk++; if (apu_req_o !== 1'b1) $display("FAIL b2b_req%0d got=%b exp=1", i, apu_req_o); else n_pass++;
    end
    rand_payload();
    #1;
    n_chk++; if (core_gnt_o !== 1'b0) $display("FAIL b2b_5th_held got=%b exp=0", core_gnt_o); else n_pass++;
    tick();
    apu_gnt_i = 0;
    for (int k = 0; k < 4; k++) begin
      apu_rvalid_i = 1; apu_rID_i = 9'(order[k]); apu_rdata_i = $urandom; apu_rflags_i = 5'($urandom);
      #1;
      n_chk++; if (core_gnt_o !== 1'b0) $display("FAIL b2b_held_rsp%0d got=%b exp=0", k, core_gnt_o); else n_pass++;
      tick();
    end
    apu_rvalid_i = 0; core_rready_i = 1;
    #1;
    n_chk++; if (core_gnt_o !== 1'b0) $display("FAIL b2b_held_pop got=%b exp=0", core_gnt_o); else n_pass++;
    n_chk++; if (core_rtag_o !== 5'd10) $display("FAIL b2b_head_tag got=%h exp=0a", core_rtag_o); else n_pass++;
    tick();
    core_rready_i = 0;
    #1;
    n_chk++; if (core_gnt_o !== 1'b1) $display("FAIL b2b_5th_gnt got=%b exp=1", core_gnt_o); else n_pass++;
    tick();
    core_req_i = 0;
    n_chk++; if (apu_ID_o !== 9'd0) $display("FAIL b2b_5th_id got=%h exp=0", apu_ID_o); else n_pass++;
    while (m_fifo.size() > 0) begin
      core_rready_i = 1;
      n_chk++; if (core_rtag_o !== m_fifo[0].t || core_rdata_o !== m_fifo[0].d)
        $display("FAIL b2b_drain got=%h/%h exp=%h/%h", core_rtag_o, core_rdata_o, m_fifo[0].t, m_fifo[0].d);
      else n_pass++;
      tick();
    end
    flush();
  endtask

  task automatic test_stall();
    logic [8:0]  id0;
    logic [95:0] ops0, ops1;
    do_reset();
    rand_payload(); core_req_i = 1;
    tick();
    id0 = apu_ID_o; ops0 = m_ops;
    rand_payload(); ops1 = core_operands_i;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (core_gnt_o !== 1'b0) $display("FAIL stall_gnt%0d got=%b exp=0", i, core_gnt_o); else n_pass++;
      tick();
      n_chk++; if (apu_req_o !== 1'b1 || apu_ID_o !== 9'd0 || apu_operands_o !== ops0)
        $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/000/%h", i, apu_req_o, apu_ID_o, apu_operands_o, ops0);
      else n_pass++;
    end
    n_chk++; if (id0 !== 9'd0) $display("FAIL stall_id0 got=%h exp=0", id0); else n_pass++;
    apu_gnt_i = 1;
    #1;
    n_chk++; if (core_gnt_o !== 1'b1) $display("FAIL stall_gnt_release got=%b exp=1", core_gnt_o); else n_pass++;
    tick();
    core_req_i = 0;
    n_chk++; if (apu_ID_o !== 9'd1 || apu_operands_o !== ops1)
      $display("FAIL stall_next got=%h/%h exp=001/%h", apu_ID_o, apu_operands_o, ops1);
    else n_pass++;
    flush();
  endtask

  task automatic test_out_of_order();
    logic [31:0] d0, d1;
    do_reset();
    d0 = $urandom; d1 = $urandom;
    apu_gnt_i = 1; core_req_i = 1;
    rand_payload(); core_tag_i = 5'h01; tick();
    rand_payload(); core_tag_i = 5'h02; tick();
    core_req_i = 0; tick();
    apu_gnt_i = 0;
    apu_rvalid_i = 1; apu_rID_i = 9'd1; apu_rdata_i = d1; tick();
    apu_rID_i = 9'd0; apu_rdata_i = d0; tick();
    apu_rvalid_i = 0;
    n_chk++; if (core_rvalid_o !== 1'b1 || core_rtag_o !== 5'h02 || core_rdata_o !== d1)
      $display("FAIL ooo_first got=%b/%h/%h exp=1/02/%h", core_rvalid_o, core_rtag_o, core_rdata_o, d1);
    else n_pass++;
    core_rready_i = 1; tick();
    n_chk++; if (core_rvalid_o !== 1'b1 || core_rtag_o !== 5'h01 || core_rdata_o !== d0)
      $display("FAIL ooo_second got=%b/%h/%h exp=1/01/%h", core_rvalid_o, core_rtag_o, core_rdata_o, d0);
    else n_pass++;
    tick();
    core_rready_i = 0;
    n_chk++; if (core_rvalid_o !== 1'b0) $display("FAIL ooo_empty got=%b exp=0", core_rvalid_o); else n_pass++;
  endtask

  task automatic test_fifo_full();
    do_reset();
    apu_gnt_i = 1; core_req_i = 1;
    for (int i = 0; i < 4; i++) begin rand_payload(); tick(); end
    core_req_i = 0; tick();
    for (int s = 0; s < 4; s++) begin
      apu_rvalid_i = 1; apu_rID_i = 9'(s); apu_rdata_i = $urandom; tick();
    end
    apu_rvalid_i = 0; core_req_i = 1; rand_payload();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (core_gnt_o !== 1'b0 || core_rvalid_o !== 1'b1)
        $display("FAIL full_hold%0d got=%b/%b exp=0/1", i, core_gnt_o, core_rvalid_o);
      else n_pass++;
      tick();
    end
    core_rready_i = 1; tick();
    #1;
    n_chk++; if (core_gnt_o !== 1'b1) $display("FAIL full_after_pop got=%b exp=1", core_gnt_o); else n_pass++;
    tick();
    core_rready_i = 0;
    #1;
    n_chk++; if (core_gnt_o !== 1'b1) $display("FAIL full_pop_accept got=%b exp=1", core_gnt_o); else n_pass++;
    tick();
    core_req_i = 0;
    #1;
    n_chk++; if (core_gnt_o !== 1'b0) $display("FAIL full_refill got=%b exp=0", core_gnt_o); else n_pass++;
    flush();
  endtask

  task automatic test_bad_id();
    do_reset();
    apu_rvalid_i = 1; apu_rID_i = {7'h05, 2'd1}; tick();
    apu_rvalid_i = 0;
    n_chk++; if (resp_err_o !== 1'b1 || core_rvalid_o !== 1'b0)
      $display("FAIL bad_src got=%b/%b exp=1/0", resp_err_o, core_rvalid_o);
    else n_pass++;
    tick();
    n_chk++; if (resp_err_o !== 1'b0) $display("FAIL bad_src_pulse got=%b exp=0", resp_err_o); else n_pass++;
    apu_rvalid_i = 1; apu_rID_i = 9'd2; tick();
    apu_rvalid_i = 0;
    n_chk++; if (resp_err_o !== 1'b1 || core_rvalid_o !== 1'b0)
      $display("FAIL bad_idle got=%b/%b exp=1/0", resp_err_o, core_rvalid_o);
    else n_pass++;
    apu_gnt_i = 1; core_req_i = 1;
    rand_payload(); tick();
    rand_payload(); tick();
    core_req_i = 0; tick();
    apu_gnt_i = 0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (busy_o !== 1'b0 || apu_ID_o !== 9'd0)
      $display("FAIL async_rst got=%b/%h exp=0/000", busy_o, apu_ID_o);
    else n_pass++;
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    apu_rvalid_i = 1; apu_rID_i = 9'd0; tick();
    apu_rvalid_i = 0;
    n_chk++; if (resp_err_o !== 1'b1 || core_rvalid_o !== 1'b0)
      $display("FAIL stale_after_rst got=%b/%b exp=1/0", resp_err_o, core_rvalid_o);
    else n_pass++;
  endtask

  task automatic test_random();
    int s;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_payload();
      core_req_i    = ($urandom_range(0, 99) < 60);
      apu_gnt_i     = ($urandom_range(0, 99) < 70);
      core_rready_i = ($urandom_range(0, 99) < 45);
      apu_rvalid_i  = ($urandom_range(0, 99) < 40);
      s = $urandom_range(0, NB - 1);
      apu_rID_i     = ($urandom_range(0, 9) == 0) ? 9'($urandom) : {7'(SRC), 2'(s)};
      apu_rdata_i   = $urandom;
      apu_rflags_i  = 5'($urandom);
      #1;
      n_chk++; if (core_gnt_o !== exp_gnt()) $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, core_gnt_o, exp_gnt()); else n_pass++;
      tick();
      n_chk++; if (apu_req_o !== m_pend || apu_ID_o !== m_id)
        $display("FAIL rnd_req c=%0d got=%b/%h exp=%b/%h", c, apu_req_o, apu_ID_o, m_pend, m_id);
      else n_pass++;
      n_chk++; if (apu_operands_o !== m_ops || apu_op_o !== m_op || apu_flags_o !== m_flags)
        $display("FAIL rnd_payload c=%0d got=%h/%h/%h exp=%h/%h/%h", c, apu_operands_o, apu_op_o, apu_flags_o, m_ops, m_op, m_flags);
      else n_pass++;
      n_chk++; if (core_rvalid_o !== (m_fifo.size() != 0))
        $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, core_rvalid_o, m_fifo.size() != 0);
      else n_pass++;
      if (m_fifo.size() != 0) begin
        n_chk++; if ({core_rdata_o, core_rflags_o, core_rtag_o} !== m_fifo[0])
          $display("FAIL rnd_head c=%0d got=%h exp=%h", c, {core_rdata_o, core_rflags_o, core_rtag_o}, m_fifo[0]);
        else n_pass++;
      end
      n_chk++; if (resp_err_o !== m_err || busy_o !== (m_credits != 0))
        $display("FAIL rnd_status c=%0d got=%b/%b exp=%b/%b", c, resp_err_o, busy_o, m_err, m_credits != 0);
      else n_pass++;
    end
    flush();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    test_reset();
    test_single_op();
    test_back_to_back();
    test_stall();
    test_out_of_order();
    test_fifo_full();
    test_bad_id();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
